// File: rtl/bound_accumulator_if.sv
// bound_accumulator_if: clause stream in, accumulated bound interval and status out.
interface bound_accumulator_if #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT = 4
);
  localparam int W = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int C = MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT;
  logic in_start;
  logic in_valid;
  logic in_last;
  logic signed [W-1:0] in_bias;
  logic in_variable_to_be_unchanged_sign;
  logic in_active;
  logic signed [W-1:0] out_lower_bound;
  logic signed [W-1:0] out_upper_bound;
  logic out_empty;
  logic out_done;
  logic out_busy;
  logic [C-1:0] out_clause_count;
  modport master (
    output in_start, in_valid, in_last, in_bias, in_variable_to_be_unchanged_sign, in_active,
    input out_lower_bound, out_upper_bound, out_empty, out_done, out_busy, out_clause_count
  );
  modport slave (
    input in_start, in_valid, in_last, in_bias, in_variable_to_be_unchanged_sign, in_active,
    output out_lower_bound, out_upper_bound, out_empty, out_done, out_busy, out_clause_count
  );
endinterface

// File: rtl/bound_accumulator.sv
// bound_accumulator: intersects (+/-)y + b <= 0 clauses into a signed [lower, upper] interval for y.
module bound_accumulator #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT = 4
) (
  input logic in_clk,
  input logic in_reset,
  bound_accumulator_if.slave bus
);
  localparam int W = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int C = MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT;
  localparam logic signed [W-1:0] LO_INIT = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] HI_INIT = {1'b0, {(W-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t r_state, w_state;
  logic signed [W-1:0] r_lower, r_upper, w_lower, w_upper, w_neg_sat;
  logic signed [W:0] w_neg;
  logic [C-1:0] r_count, w_count;
  logic r_empty, w_take, w_lo_hit, w_hi_hit;
  always_comb begin
    w_take = (r_state == ACCUM) && bus.in_valid && !bus.in_start;
    w_neg = -{bus.in_bias[W-1], bus.in_bias};
    // only -(-2^(W-1)) overflows W bits; clamp it to the largest positive value
    w_neg_sat = (w_neg[W] != w_neg[W-1]) ? HI_INIT : w_neg[W-1:0];
    w_lo_hit = w_take && bus.in_active && !bus.in_variable_to_be_unchanged_sign && (bus.in_bias > r_lower);
    w_hi_hit = w_take && bus.in_active && bus.in_variable_to_be_unchanged_sign && (w_neg_sat < r_upper);
    w_lower = bus.in_start ? LO_INIT : w_lo_hit ? bus.in_bias : r_lower;
    w_upper = bus.in_start ? HI_INIT : w_hi_hit ? w_neg_sat : r_upper;
    w_count = bus.in_start ? '0 : (w_take && bus.in_active && !(&r_count)) ? r_count + 1'b1 : r_count;
    w_state = bus.in_start ? ACCUM :
              (r_state == ACCUM) ? ((w_take && bus.in_last) ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state <= IDLE;
      r_lower <= LO_INIT;
      r_upper <= HI_INIT;
      r_count <= '0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_state;
      r_lower <= w_lower;
      r_upper <= w_upper;
      r_count <= w_count;
      r_empty <= w_lower > w_upper;
    end
  end
  assign bus.out_lower_bound = r_lower;
  assign bus.out_upper_bound = r_upper;
  assign bus.out_empty = r_empty;
  assign bus.out_clause_count = r_count;
  assign bus.out_busy = r_state == ACCUM;
  assign bus.out_done = r_state == DONE;
endmodule

// File: tb/tb_bound_accumulator.sv
// tb_bound_accumulator: directed scenarios plus random clause streams against an integer interval model.
module tb_bound_accumulator;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int m_phase, m_lo, m_hi, m_cnt;
  bound_accumulator_if #(8, 4) bus ();
  bound_accumulator #(
    .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT(8),
    .MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT(4)
  ) dut (
    .in_clk(clk),
    .in_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // one clock: drive inputs, advance model at the edge, leave time 1 after the edge for sampling
  task automatic step(input bit rs, input bit st, input bit v, input bit l, input int b, input bit s, input bit a);
    int nb;
    rst = rs;
    bus.in_start = st;
    bus.in_valid = v;
    bus.in_last = l;
    bus.in_bias = 8'(b);
    bus.in_variable_to_be_unchanged_sign = s;
    bus.in_active = a;
    @(posedge clk);
    if (rs) begin
      m_phase = 0; m_lo = -128; m_hi = 127; m_cnt = 0;
    end else if (st) begin
      m_phase = 1; m_lo = -128; m_hi = 127; m_cnt = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1 && v) begin
      if (a) begin
        nb = (-b > 127) ? 127 : -b;
        if (s) m_hi = (nb < m_hi) ? nb : m_hi;
        else m_lo = (b > m_lo) ? b : m_lo;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
      if (l) m_phase = 2;
    end
    #1;
    rst = 1'b0;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    vectors += 6;
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL reset_lower got %0d want -128", int'(bus.out_lower_bound)); end
    if (int'(bus.out_upper_bound) !== 127) begin miscompares++; $display("FAIL reset_upper got %0d want 127", int'(bus.out_upper_bound)); end
    if (bus.out_empty !== 1'b0) begin miscompares++; $display("FAIL reset_empty got %b want 0", bus.out_empty); end
    if (bus.out_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.out_done); end
    if (bus.out_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.out_busy); end
    if (int'(bus.out_clause_count) !== 0) begin miscompares++; $display("FAIL reset_count got %0d want 0", int'(bus.out_clause_count)); end
  endtask

  task automatic test_normal();
    step(0, 1, 0, 0, 0, 0, 0);
    vectors += 1;
    if (bus.out_busy !== 1'b1) begin miscompares++; $display("FAIL normal_busy got %b want 1", bus.out_busy); end
    step(0, 0, 1, 0, 2, 1, 1);
    vectors += 1;
    if (int'(bus.out_upper_bound) !== -2) begin miscompares++; $display("FAIL normal_upper1 got %0d want -2", int'(bus.out_upper_bound)); end
    step(0, 0, 1, 1, -5, 0, 1);
    vectors += 6;
    if (bus.out_done !== 1'b1) begin miscompares++; $display("FAIL normal_done got %b want 1", bus.out_done); end
    if (bus.out_busy !== 1'b0) begin miscompares++; $display("FAIL normal_busy_done got %b want 0", bus.out_busy); end
    if (int'(bus.out_lower_bound) !== -5) begin miscompares++; $display("FAIL normal_lower got %0d want -5", int'(bus.out_lower_bound)); end
    if (int'(bus.out_upper_bound) !== -2) begin miscompares++; $display("FAIL normal_upper got %0d want -2", int'(bus.out_upper_bound)); end
    if (bus.out_empty !== 1'b0) begin miscompares++; $display("FAIL normal_empty got %b want 0", bus.out_empty); end
    if (int'(bus.out_clause_count) !== 2) begin miscompares++; $display("FAIL normal_count got %0d want 2", int'(bus.out_clause_count)); end
    step(0, 0, 0, 0, 0, 0, 0);
    vectors += 2;
    if (bus.out_done !== 1'b0) begin miscompares++; $display("FAIL normal_done_pulse got %b want 0", bus.out_done); end
    if (int'(bus.out_lower_bound) !== -5) begin miscompares++; $display("FAIL normal_hold_lower got %0d want -5", int'(bus.out_lower_bound)); end
  endtask

  task automatic test_empty();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 3, 0, 1);
    step(0, 0, 1, 1, 0, 1, 1);
    vectors += 4;
    if (int'(bus.out_lower_bound) !== 3) begin miscompares++; $display("FAIL empty_lower got %0d want 3", int'(bus.out_lower_bound)); end
    if (int'(bus.out_upper_bound) !== 0) begin miscompares++; $display("FAIL empty_upper got %0d want 0", int'(bus.out_upper_bound)); end
    if (bus.out_empty !== 1'b1) begin miscompares++; $display("FAIL empty_flag got %b want 1", bus.out_empty); end
    if (int'(bus.out_clause_count) !== 2) begin miscompares++; $display("FAIL empty_count got %0d want 2", int'(bus.out_clause_count)); end
    step(0, 0, 1, 0, 50, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    vectors += 2;
    if (bus.out_empty !== 1'b1) begin miscompares++; $display("FAIL empty_hold got %b want 1", bus.out_empty); end
    if (int'(bus.out_lower_bound) !== 3) begin miscompares++; $display("FAIL empty_idle_ignore got %0d want 3", int'(bus.out_lower_bound)); end
  endtask

  task automatic test_inactive_sat();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 9, 1, 0);
    vectors += 4;
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL inact_lower got %0d want -128", int'(bus.out_lower_bound)); end
    if (int'(bus.out_upper_bound) !== 127) begin miscompares++; $display("FAIL inact_upper got %0d want 127", int'(bus.out_upper_bound)); end
    if (int'(bus.out_clause_count) !== 0) begin miscompares++; $display("FAIL inact_count got %0d want 0", int'(bus.out_clause_count)); end
    if (bus.out_done !== 1'b1) begin miscompares++; $display("FAIL inact_done got %b want 1", bus.out_done); end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, -128, 1, 1);
    vectors += 3;
    if (int'(bus.out_upper_bound) !== 127) begin miscompares++; $display("FAIL negsat_upper got %0d want 127", int'(bus.out_upper_bound)); end
    if (int'(bus.out_clause_count) !== 1) begin miscompares++; $display("FAIL negsat_count got %0d want 1", int'(bus.out_clause_count)); end
    if (bus.out_done !== 1'b1) begin miscompares++; $display("FAIL negsat_done got %b want 1", bus.out_done); end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    step(0, 0, 1, 1, 20, 0, 1);
    vectors += 3;
    if (int'(bus.out_clause_count) !== 1) begin miscompares++; $display("FAIL idle_valid_count got %0d want 1", int'(bus.out_clause_count)); end
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL idle_valid_lower got %0d want -128", int'(bus.out_lower_bound)); end
    if (bus.out_busy !== 1'b0) begin miscompares++; $display("FAIL idle_valid_busy got %b want 0", bus.out_busy); end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 4, 0, 1);
    vectors += 1;
    if (int'(bus.out_lower_bound) !== 4) begin miscompares++; $display("FAIL restart_pre got %0d want 4", int'(bus.out_lower_bound)); end
    step(0, 1, 1, 1, 60, 0, 1);
    vectors += 4;
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL restart_lower got %0d want -128", int'(bus.out_lower_bound)); end
    if (int'(bus.out_clause_count) !== 0) begin miscompares++; $display("FAIL restart_count got %0d want 0", int'(bus.out_clause_count)); end
    if (bus.out_busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b want 1", bus.out_busy); end
    if (bus.out_done !== 1'b0) begin miscompares++; $display("FAIL restart_done got %b want 0", bus.out_done); end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 4, 0, 1);
    step(1, 1, 1, 1, 7, 0, 1);
    vectors += 6;
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL rstmid_lower got %0d want -128", int'(bus.out_lower_bound)); end
    if (int'(bus.out_upper_bound) !== 127) begin miscompares++; $display("FAIL rstmid_upper got %0d want 127", int'(bus.out_upper_bound)); end
    if (bus.out_empty !== 1'b0) begin miscompares++; $display("FAIL rstmid_empty got %b want 0", bus.out_empty); end
    if (bus.out_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", bus.out_done); end
    if (bus.out_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.out_busy); end
    if (int'(bus.out_clause_count) !== 0) begin miscompares++; $display("FAIL rstmid_count got %0d want 0", int'(bus.out_clause_count)); end
    step(0, 0, 1, 1, 7, 0, 1);
    vectors += 2;
    if (bus.out_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle_done got %b want 0", bus.out_done); end
    if (int'(bus.out_lower_bound) !== -128) begin miscompares++; $display("FAIL rstmid_idle_lower got %0d want -128", int'(bus.out_lower_bound)); end
  endtask

  task automatic test_count_sat();
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, i - 8, i % 2, 1);
    vectors += 1;
    if (int'(bus.out_clause_count) !== 15) begin miscompares++; $display("FAIL cntsat_16 got %0d want 15", int'(bus.out_clause_count)); end
    step(0, 0, 1, 1, 1, 0, 1);
    vectors += 2;
    if (int'(bus.out_clause_count) !== 15) begin miscompares++; $display("FAIL cntsat_last got %0d want 15", int'(bus.out_clause_count)); end
    if (bus.out_done !== 1'b1) begin miscompares++; $display("FAIL cntsat_done got %b want 1", bus.out_done); end
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, b, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
      vectors += 6;
      if (int'(bus.out_lower_bound) !== m_lo) begin miscompares++; $display("FAIL rand_lower cyc %0d got %0d want %0d", i, int'(bus.out_lower_bound), m_lo); end
      if (int'(bus.out_upper_bound) !== m_hi) begin miscompares++; $display("FAIL rand_upper cyc %0d got %0d want %0d", i, int'(bus.out_upper_bound), m_hi); end
      if (bus.out_empty !== (m_lo > m_hi)) begin miscompares++; $display("FAIL rand_empty cyc %0d got %b want %b", i, bus.out_empty, m_lo > m_hi); end
      if (bus.out_busy !== (m_phase == 1)) begin miscompares++; $display("FAIL rand_busy cyc %0d got %b want %b", i, bus.out_busy, m_phase == 1); end
      if (bus.out_done !== (m_phase == 2)) begin miscompares++; $display("FAIL rand_done cyc %0d got %b want %b", i, bus.out_done, m_phase == 2); end
      if (int'(bus.out_clause_count) !== m_cnt) begin miscompares++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, int'(bus.out_clause_count), m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_bias = '0;
    bus.in_variable_to_be_unchanged_sign = 1'b0;
    bus.in_active = 1'b0;
    m_phase = 0; m_lo = -128; m_hi = 127; m_cnt = 0;
    test_reset();
    test_normal();
    test_empty();
    test_inactive_sat();
    test_restart();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bound_accumulator.md
BOUND_ACCUMULATOR -- requirements
Module: bound_accumulator

Interface
REQ-001 The block SHALL have parameter MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, default 8, giving the signed width W of biases and bounds.
REQ-002 The block SHALL have parameter MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT, default 4, giving the width C of the active-clause counter.
REQ-003 in_clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-004 in_reset  input  1  synchronous, active-high reset.
REQ-005 in_start  input  1  begin a new accumulation for one chosen variable.
REQ-006 in_valid  input  1  one reduced clause is presented this cycle.
REQ-007 in_last  input  1  qualifies in_valid; marks the final clause of the set.
REQ-008 in_bias  input  W  signed bias b of the reduced clause (+/-)y + b <= 0.
REQ-009 in_variable_to_be_unchanged_sign  input  1  1: +y + b <= 0 (upper bound); 0: -y + b <= 0 (lower bound).
REQ-010 in_active  input  1  1: the clause constrains the variable; 0: the clause is ignored.
REQ-011 out_lower_bound  output  W  signed accumulated lower bound on y.
REQ-012 out_upper_bound  output  W  signed accumulated upper bound on y.
REQ-013 out_empty  output  1  1 when out_lower_bound > out_upper_bound (signed comparison).
REQ-014 out_done  output  1  one-cycle pulse: the result is complete.
REQ-015 out_busy  output  1  high while in state ACCUM.
REQ-016 out_clause_count  output  C  number of active clauses accepted since the last in_start.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 Transitions: IDLE to ACCUM on in_start; ACCUM to DONE on in_valid & in_last; DONE to IDLE unconditionally after 1 cycle.
REQ-019 in_start in any state SHALL do the following at the same edge: set lower to -2^(W-1), set upper to 2^(W-1)-1, clear the count, and enter ACCUM; this includes a restart from ACCUM or DONE.
REQ-020 in_valid SHALL be ignored in IDLE, in DONE, and in any cycle where in_start is high.
REQ-021 In ACCUM, when in_valid & in_active & sign=0, lower SHALL become max(lower, in_bias).
REQ-022 In ACCUM, when in_valid & in_active & sign=1, upper SHALL become min(upper, -in_bias); the negation SHALL be computed in W+1 bits and saturated to 2^(W-1)-1, so that in_bias = -2^(W-1) yields 2^(W-1)-1.
REQ-023 When in_valid & !in_active, the bounds and the count SHALL remain unchanged; in_last SHALL still be honoured.
REQ-024 The count SHALL increment on each accepted active clause and saturate at 2^C-1.
REQ-025 Latency: a clause sampled at edge N SHALL be reflected in the bounds, count and out_empty after edge N; with in_last, out_done SHALL be high for exactly the cycle after edge N.
REQ-026 out_empty SHALL be a registered value consistent with the registered bounds in every cycle.
REQ-027 The bounds, out_empty and count SHALL hold after DONE until the next in_start or in_reset.
REQ-028 out_busy SHALL be 1 in ACCUM only, and out_done SHALL be 1 in DONE only.

Reset
REQ-029 When in_reset is high at a rising edge, the block SHALL enter IDLE with out_lower_bound=-2^(W-1), out_upper_bound=2^(W-1)-1, out_empty=0, out_done=0, out_busy=0 and out_clause_count=0.
REQ-030 in_reset SHALL take priority over in_start and in_valid, including in the middle of an accumulation.

Verification (W=8, C=4)
REQ-031 Normal set: start; (b=2, s=1, act) -> upper=-2; (b=-5, s=0, act, last) -> next cycle done=1, lower=-5, upper=-2, empty=0, count=2.
REQ-032 Empty interval: start; (b=3, s=0, act); (b=0, s=1, act, last) -> lower=3, upper=0, empty=1, count=2.
REQ-033 Inactive clause and saturation: start; (b=9, s=1, inactive, last) -> lower=-128, upper=127, count=0, done=1; start; (b=-128, s=1, act, last) -> upper=127.
REQ-034 Restart and ignored input: in_valid in IDLE leaves state unchanged; start, (b=4, s=0, act), start again -> lower=-128, count=0, busy=1.
REQ-035 Reset mid-operation: start, (b=4, s=0, act), in_reset=1 with in_valid=1 -> the next cycle shows all reset values of REQ-029 and state IDLE.
REQ-036 Count saturation: 16 active clauses then last -> out_clause_count=15.
